// File: rtl/wb_sram_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM bridge.
package wb_sram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RWAIT,
    ACK,
    ERR
  } t_wsb_state;

  localparam int C_WSB_MAX_RD_LATENCY = 4;
  // Wide enough to hold the largest legal latency value.
  localparam int C_WSB_CNT_W          = $clog2(C_WSB_MAX_RD_LATENCY + 1);

endpackage

// File: rtl/wb_sram_rd_delay.sv
// SRAM read-latency tracker: loaded on the read strobe, pulses o_capture in the
// last wait cycle so the caller samples mem_data_i on that edge.
module wb_sram_rd_delay
  import wb_sram_bridge_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_clr,
  output logic o_capture
);

  logic [C_WSB_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= C_WSB_CNT_W'(RD_LATENCY);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Count hits 0 on the edge that ends this cycle.
  assign o_capture = (r_cnt == C_WSB_CNT_W'(1));

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone pipelined slave in front of a single-port synchronous SRAM.
// Build option WB_SRAM_BYTE_SEL_EN: pass wb_sel_i through as SRAM byte enables.
module wb_sram_bridge
  import wb_sram_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH+1:0]   wb_adr_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_stall_o,
  output logic                    wb_rty_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_data_o,
  input  logic [DATA_WIDTH-1:0]   mem_data_i,
  output logic                    mem_wr_o,
  output logic                    mem_rd_o,
  output logic [DATA_WIDTH/8-1:0] mem_bwe_o
);

  localparam int NB = DATA_WIDTH / 8;

  t_wsb_state            r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [NB-1:0]         r_bwe;

  logic w_busy, w_accept, w_sel_ok, w_good;
  logic w_wr, w_rd, w_ack, w_err;
  logic w_start, w_clr, w_cap, w_capture;
  logic w_unused_adr;

  // Byte address LSBs select nothing in a word-wide SRAM.
  assign w_unused_adr = ^wb_adr_i[1:0];

`ifdef WB_SRAM_BYTE_SEL_EN
  assign w_sel_ok = 1'b1;
`else
  assign w_sel_ok = &wb_sel_i;
`endif

  assign w_busy   = (r_state == WRITE) || (r_state == READ) || (r_state == RWAIT);
  assign w_accept = wb_cyc_i && wb_stb_i && !w_busy;
  assign w_good   = w_accept && (!wb_we_i || w_sel_ok);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_wr    = 1'b0;
    w_rd    = 1'b0;
    w_ack   = 1'b0;
    w_err   = 1'b0;
    w_start = 1'b0;
    w_clr   = 1'b0;
    w_cap   = 1'b0;
    case (r_state)
      IDLE, ACK, ERR: begin
        w_ack = (r_state == ACK);
        w_err = (r_state == ERR);
        if (!w_accept)    w_next = IDLE;
        else if (!wb_we_i) w_next = READ;
        else if (w_sel_ok) w_next = WRITE;
        else               w_next = ERR;
      end
      WRITE: begin
        w_wr   = 1'b1;
        w_next = wb_cyc_i ? ACK : IDLE;
      end
      READ: begin
        w_rd    = 1'b1;
        w_start = wb_cyc_i;
        w_next  = wb_cyc_i ? RWAIT : IDLE;
      end
      RWAIT: begin
        // An abort drops the outstanding read; its data is never captured.
        if (!wb_cyc_i) begin
          w_clr  = 1'b1;
          w_next = IDLE;
        end else if (w_capture) begin
          w_cap  = 1'b1;
          w_next = ACK;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  wb_sram_rd_delay #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_delay (
    .i_clk     (clk_i),
    .i_rst_n   (rst_n_i),
    .i_start   (w_start),
    .i_clr     (w_clr),
    .o_capture (w_capture)
  );

  // SRAM-facing registers only move on transfers that will strobe the SRAM,
  // so they hold steady across rejected writes.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_bwe   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_good) r_addr <= wb_adr_i[ADDR_WIDTH+1:2];
      if (w_good && wb_we_i) begin
        r_wdata <= wb_dat_i;
`ifdef WB_SRAM_BYTE_SEL_EN
        r_bwe   <= wb_sel_i;
`else
        r_bwe   <= '1;
`endif
      end
      if (w_cap) r_rdata <= mem_data_i;
    end
  end

  assign wb_dat_o   = r_rdata;
  assign wb_ack_o   = w_ack;
  assign wb_err_o   = w_err;
  assign wb_stall_o = w_busy;
  assign wb_rty_o   = 1'b0;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_wdata;
  assign mem_wr_o   = w_wr;
  assign mem_rd_o   = w_rd;
  assign mem_bwe_o  = w_wr ? r_bwe : '0;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge (default build, RD_LATENCY=3) with a
// transaction-timeline reference model checked every cycle.
module tb_wb_sram_bridge;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW+1:0] adr = '0;
  logic [NB-1:0] sel = '0;
  logic [DW-1:0] dat_w = '0;
  logic [DW-1:0] dat_r, mem_do, mem_di;
  logic          ack, err, stall, rty, mwr, mrd;
  logic [AW-1:0] maddr;
  logic [NB-1:0] bwe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_sram_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w),
    .wb_dat_o(dat_r), .wb_ack_o(ack), .wb_err_o(err),
    .wb_stall_o(stall), .wb_rty_o(rty),
    .mem_addr_o(maddr), .mem_data_o(mem_do), .mem_data_i(mem_di),
    .mem_wr_o(mwr), .mem_rd_o(mrd), .mem_bwe_o(bwe)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // SRAM environment: data appears L cycles after the read strobe.
  logic [DW-1:0] sram  [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:L-1];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) rpipe[i] <= 32'hBAD0_BAD0;
    end else begin
      rpipe[0] <= mrd ? sram[maddr] : 32'hBAD0_BAD0;
      for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end
    if (mwr)
      for (int b = 0; b < NB; b++)
        if (bwe[b]) sram[maddr][8*b +: 8] <= mem_do[8*b +: 8];
  end
  assign mem_di = rpipe[L-1];

  // Reference model: on each accepted request, schedule the cycle numbers at
  // which each output event must happen.
  int            cnum = 0;
  bit            mvalid = 1'b0;
  int            ack_at = -1, err_at = -1, wr_at = -1, rd_at = -1, cap_at = -1;
  int            bfirst = -1, blast = -2;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rd = '0, e_dat = '0;
  logic [DW-1:0] mmem [0:(1<<AW)-1];

  always @(posedge clk) begin
    int t;
    bit stalled;
    t = cnum;
    if (!rst_n) begin
      ack_at = -1; err_at = -1; wr_at = -1; rd_at = -1; cap_at = -1;
      bfirst = -1; blast = -2;
      e_addr = '0; e_wdata = '0; e_dat = '0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      stalled = (t >= bfirst) && (t <= blast);
      if (stalled && !cyc) begin
        ack_at = -1; cap_at = -1; blast = t;
      end else if (!stalled && cyc && stb) begin
        if (!we) begin
          e_addr = adr[AW+1:2];
          e_rd   = mmem[e_addr];
          rd_at  = t + 1; bfirst = t + 1; blast = t + 1 + L;
          cap_at = t + 1 + L; ack_at = t + 2 + L;
        end else if (&sel) begin
          e_addr  = adr[AW+1:2];
          e_wdata = dat_w;
          mmem[e_addr] = dat_w;
          wr_at = t + 1; bfirst = t + 1; blast = t + 1; ack_at = t + 2;
        end else begin
          err_at = t + 1;
        end
      end
      if (t == cap_at) e_dat = e_rd;
    end
    cnum = cnum + 1;
  end

  always @(negedge clk) begin
    int c;
    if (mvalid) begin
      c = cnum;
      chk("m_ack",   64'(ack),   64'(c == ack_at));
      chk("m_err",   64'(err),   64'(c == err_at));
      chk("m_stall", 64'(stall), 64'((c >= bfirst) && (c <= blast)));
      chk("m_wr",    64'(mwr),   64'(c == wr_at));
      chk("m_rd",    64'(mrd),   64'(c == rd_at));
      chk("m_rty",   64'(rty),   64'(0));
      chk("m_dat",   64'(dat_r), 64'(e_dat));
      if (c == wr_at || c == rd_at) chk("m_addr", 64'(maddr), 64'(e_addr));
      if (c == wr_at) begin
        chk("m_wdata", 64'(mem_do), 64'(e_wdata));
        chk("m_bwe",   64'(bwe),    64'(4'hF));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack"},   64'(ack),    64'(0));
    chk({nm, "_err"},   64'(err),    64'(0));
    chk({nm, "_stall"}, 64'(stall),  64'(0));
    chk({nm, "_rty"},   64'(rty),    64'(0));
    chk({nm, "_wr"},    64'(mwr),    64'(0));
    chk({nm, "_rd"},    64'(mrd),    64'(0));
    chk({nm, "_dat"},   64'(dat_r),  64'(0));
    chk({nm, "_addr"},  64'(maddr),  64'(0));
    chk({nm, "_mdata"}, 64'(mem_do), 64'(0));
    chk({nm, "_bwe"},   64'(bwe),    64'(0));
  endtask

  task automatic do_write(input logic [AW+1:0] a, input logic [DW-1:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = 4'hF;
    tick();
    stb = 1'b0;
    tick();
    cyc = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [AW+1:0] a, input logic [DW-1:0] expd, input string nm);
    bit got;
    got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    tick();
    stb = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (ack) got = 1'b1;
      else     tick();
    end
    chk({nm, "_acked"}, 64'(got),   64'(1));
    chk({nm, "_data"},  64'(dat_r), 64'(expd));
    cyc = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single write, literal timing
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h14; dat_w = 32'hDEAD_BEEF; sel = 4'hF;
    tick();
    stb = 1'b0;
    chk("wr1_strobe", 64'(mwr),    64'(1));
    chk("wr1_addr",   64'(maddr),  64'(5));
    chk("wr1_data",   64'(mem_do), 64'(32'hDEAD_BEEF));
    chk("wr1_bwe",    64'(bwe),    64'(4'hF));
    chk("wr1_stall",  64'(stall),  64'(1));
    tick();
    chk("wr1_ack", 64'(ack), 64'(1));
    cyc = 1'b0;
    tick();

    // Read with latency 3, literal timing
    do_write(8'h08, 32'h1234_5678);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h08;
    tick();
    stb = 1'b0;
    chk("rd1_strobe", 64'(mrd),   64'(1));
    chk("rd1_addr",   64'(maddr), 64'(2));
    chk("rd1_stall1", 64'(stall), 64'(1));
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("rd1_stall", 64'(stall), 64'(1));
      chk("rd1_noack", 64'(ack),   64'(0));
    end
    tick();
    chk("rd1_ack",     64'(ack),   64'(1));
    chk("rd1_data",    64'(dat_r), 64'(32'h1234_5678));
    chk("rd1_unstall", 64'(stall), 64'(0));
    cyc = 1'b0;
    tick();

    // Partial byte select is rejected in the default build
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h20; dat_w = 32'hCAFE_F00D; sel = 4'h3;
    tick();
    stb = 1'b0;
    chk("sel3_err",   64'(err),   64'(1));
    chk("sel3_nowr",  64'(mwr),   64'(0));
    chk("sel3_noack", 64'(ack),   64'(0));
    chk("sel3_stall", 64'(stall), 64'(0));
    tick();
    chk("sel3_noack2", 64'(ack), 64'(0));
    cyc = 1'b0;
    tick();

    // Four back-to-back writes with strobe held high
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      adr   = 8'(8'h40 + 4 * i);
      dat_w = 32'hA000_0000 + 32'(i);
      chk("b2b_acc_stall", 64'(stall), 64'(0));
      tick();
      chk("b2b_wr",    64'(mwr),   64'(1));
      chk("b2b_stall", 64'(stall), 64'(1));
      chk("b2b_addr",  64'(maddr), 64'(16 + i));
      tick();
      chk("b2b_ack", 64'(ack), 64'(1));
    end
    stb = 1'b0; cyc = 1'b0;
    tick();
    do_read(8'h48, 32'hA000_0002, "b2b_rd");

    // Abort a read by dropping cyc in the first wait cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h44;
    tick();
    stb = 1'b0;
    tick();
    cyc = 1'b0;
    tick();
    tick();
    chk("abort_idle",  64'(stall), 64'(0));
    chk("abort_noack", 64'(ack),   64'(0));
    chk("abort_dat",   64'(dat_r), 64'(32'hA000_0002));
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h50; dat_w = 32'h55AA_55AA; sel = 4'hF;
    tick();
    stb = 1'b0;
    chk("abort_nwr", 64'(mwr), 64'(1));
    tick();
    chk("abort_nack", 64'(ack), 64'(1));
    cyc = 1'b0;
    tick();
    do_read(8'h44, 32'hA000_0001, "abort_rd");

    // Reset in the middle of a read wait
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h08;
    tick();
    stb = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst_n = 1'b1; cyc = 1'b0;
    repeat (6) begin
      chk("midrst_noack", 64'(ack), 64'(0));
      tick();
    end
    do_read(8'h08, 32'h1234_5678, "postrst_rd");
    do_read(8'h50, 32'h55AA_55AA, "final_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sram_bridge.md
# wb_sram_bridge

Parametrised Wishbone pipelined slave bridging to a single-port synchronous SRAM, supporting both reads and writes. Successor to the fixed 32-bit, write-only SRAM bus interface. Adds configurable address/data width, configurable SRAM read latency, byte-lane handling and error signalling. Sits between the register-map decoder and a memory block.

## Interface
Parameters:
- ADDR_WIDTH, 6, SRAM word-address bits; the bus byte address is wb_adr_i[ADDR_WIDTH+1:0].
- DATA_WIDTH, 32, data width in bits; must be a multiple of 8. NB = DATA_WIDTH/8.
- RD_LATENCY, 1, cycles from mem_rd_o to valid mem_data_i; legal range 1..4.

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone cycle, strobe, write
- wb_adr_i  in  ADDR_WIDTH+2  byte address; bits [1:0] ignored
- wb_sel_i  in  NB  byte selects
- wb_dat_i  in  DATA_WIDTH  write data
- wb_dat_o  out  DATA_WIDTH  read data
- wb_ack_o, wb_err_o, wb_stall_o  out  1  ack, error, stall
- wb_rty_o  out  1  tied to 0
- mem_addr_o  out  ADDR_WIDTH  SRAM word address
- mem_data_o  out  DATA_WIDTH  SRAM write data
- mem_data_i  in  DATA_WIDTH  SRAM read data
- mem_wr_o, mem_rd_o  out  1  one-cycle write and read strobes
- mem_bwe_o  out  NB  byte write enables

## Operation
- FSM states: IDLE, WRITE, READ, RWAIT, ACK, ERR.
- Accept condition: wb_cyc_i & wb_stb_i & ~wb_stall_o. On accept, register the address (adr[ADDR_WIDTH+1:2]), data, sel and we.
- IDLE/ACK/ERR: stall=0. Accept a write -> WRITE; a read -> READ; a rejected write -> ERR. No accept -> IDLE.
- WRITE: mem_wr_o=1 with the registered addr/data/bwe -> ACK.
- READ: mem_rd_o=1 with the registered addr. Load a down-counter with RD_LATENCY -> RWAIT.
- RWAIT: decrement the counter. When it reaches 0, capture mem_data_i into wb_dat_o -> ACK.
- ACK: wb_ack_o=1 for one cycle. ERR: wb_err_o=1 for one cycle.
- wb_stall_o=1 in WRITE, READ and RWAIT.
- wb_dat_o holds the last captured read value until the next capture.
- Cycle abort: if wb_cyc_i=0 in any busy state, an SRAM strobe already issued still completes, but ack/err are suppressed and the FSM enters IDLE after the current step. The FSM never returns to ACK or ERR for an aborted transfer.
- Reset: every output goes to 0 (wb_dat_o, mem_addr_o, mem_data_o, mem_bwe_o included), FSM to IDLE, counter to 0. A pending read produces no late ack.

## Timing
- Accept edge = N.
- Write: mem_wr_o high in cycle N+1; wb_ack_o in cycle N+2.
- Read: mem_rd_o high in cycle N+1; data sampled at the end of cycle N+1+RD_LATENCY; wb_dat_o valid and wb_ack_o high in cycle N+2+RD_LATENCY.
- Error: wb_err_o in cycle N+1.
- Back-to-back: a new request can be accepted in the ACK/ERR cycle. Peak throughput is one write per 2 cycles.
- Strobes are always single-cycle. mem_addr_o and mem_data_o hold their value between strobes.

## Configuration
- WB_SRAM_BYTE_SEL_EN defined: mem_bwe_o = registered wb_sel_i. Any sel pattern is accepted on write; sel = 0 gives a WRITE with mem_bwe_o = 0, acked normally.
- Not defined: mem_bwe_o is all-ones during writes. A write with wb_sel_i != all-ones goes to ERR, no mem_wr_o.
- Reads ignore wb_sel_i in both builds.

## Structure
- Package wb_sram_bridge_pkg holds:
  - enum t_wsb_state (the six states);
  - constant C_WSB_MAX_RD_LATENCY = 4;
  - counter width derived from it.
- Sub-module wb_sram_rd_delay: RD_LATENCY down-counter/valid generator. Inputs: start pulse, synchronous reset. Output: one-cycle capture pulse. It is the only natural split.

## Test plan
- DATA_WIDTH=32: write adr 0x14, data 0xDEADBEEF, sel 0xF -> cycle N+1 mem_wr_o=1, mem_addr_o=5, mem_data_o=0xDEADBEEF, mem_bwe_o=0xF; cycle N+2 wb_ack_o=1.
- RD_LATENCY=3: read adr 0x08, model returns 0x12345678 three cycles after mem_rd_o -> mem_rd_o at N+1 with mem_addr_o=2; wb_ack_o=1 and wb_dat_o=0x12345678 at N+5; stall high N+1..N+4.
- Write sel 0x3: with WB_SRAM_BYTE_SEL_EN -> mem_bwe_o=0x3, ack at N+2. Without it -> no mem_wr_o, wb_err_o=1 at N+1, wb_ack_o=0.
- Four writes with wb_stb_i held high -> accepts at N, N+2, N+4, N+6; wb_stall_o pattern 0,1,0,1,...; four acks.
- Read with RD_LATENCY=2, wb_cyc_i dropped at N+2 -> no wb_ack_o; FSM in IDLE by N+4; a new write at N+4 is accepted and acked at N+6.
- rst_n_i=0 during RWAIT -> next cycle all outputs 0; no ack afterwards; a read after reset release completes normally.
